// File: rtl/sha256_round_engine_if.sv
// ---------------------------------------------------------------------------
// sha256_round_engine_if
//   Bundles the block-level signals of the SHA-256 round engine.
//   master : front end plus constant lookup. It drives start, block_in,
//            h_in and k_const, and observes k_round, busy, done and h_out.
//   slave  : the engine itself.
// ---------------------------------------------------------------------------
interface sha256_round_engine_if;
  logic         start;     // request to compress one block
  logic [511:0] block_in;  // W0 at [511:480] .. W15 at [31:0]
  logic [255:0] h_in;      // H0 at [255:224] .. H7 at [31:0]
  logic [5:0]   k_round;   // round index presented to the constant lookup
  logic [31:0]  k_const;   // K[k_round], returned combinationally
  logic         busy;      // high in ROUND and FINAL
  logic         done;      // one-cycle pulse when h_out has been updated
  logic [255:0] h_out;     // resulting chaining value

  modport master (
    output start, block_in, h_in, k_const,
    input  k_round, busy, done, h_out
  );

  modport slave (
    input  start, block_in, h_in, k_const,
    output k_round, busy, done, h_out
  );
endinterface

// File: rtl/sha256_round_engine.sv
// ---------------------------------------------------------------------------
// sha256_round_engine
//   Iterative SHA-256 compression. It runs one round per clock for 64 rounds,
//   then spends one FINAL cycle on the chaining-value feed-forward.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active-high
//     bus  sha256_round_engine_if.slave. It carries start, block_in, h_in and
//          k_const in, and k_round, busy, done and h_out out.
//   The round constant comes from an external combinational lookup indexed
//   by k_round in the same cycle.
// ---------------------------------------------------------------------------
module sha256_round_engine (
  input  logic                        clk,
  input  logic                        rst,
  sha256_round_engine_if.slave        bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [31:0]  v_q [8];    // working variables a..h, index 0 is a
  logic [31:0]  v_d [8];
  logic [31:0]  hr_q [8];   // chaining value captured at start, H0..H7
  logic [31:0]  hr_d [8];
  logic [31:0]  w_q [16];   // message schedule window, w[0] is W_t
  logic [31:0]  w_d [16];
  logic [255:0] h_out_q, h_out_d;
  logic         done_q, done_d;

  logic [31:0]  t1, t2, w_next;

  // k_const enters here. This is the longest path: lookup -> T1 -> T1+T2 -> a.
  assign t1 = v_q[7] + big_sigma1(v_q[4])
            + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
            + bus.k_const + w_q[0];
  assign t2 = big_sigma0(v_q[0])
            + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
  assign w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  always_comb begin
    // NOTE: every _d starts as its _q. Any path that does not assign a
    // signal then holds it instead of inferring a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    hr_d    = hr_q;
    w_d     = w_q;
    h_out_d = h_out_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ROUND;
          cnt_d   = '0;
          for (int i = 0; i < 8; i++) begin
            hr_d[i] = bus.h_in[255 - 32*i -: 32];
            v_d[i]  = bus.h_in[255 - 32*i -: 32];
          end
          for (int i = 0; i < 16; i++) begin
            w_d[i] = bus.block_in[511 - 32*i -: 32];
          end
        end
      end

      ST_ROUND: begin
        v_d[7] = v_q[6];
        v_d[6] = v_q[5];
        v_d[5] = v_q[4];
        v_d[4] = v_q[3] + t1;
        v_d[3] = v_q[2];
        v_d[2] = v_q[1];
        v_d[1] = v_q[0];
        v_d[0] = t1 + t2;
        for (int i = 0; i < 15; i++) begin
          w_d[i] = w_q[i + 1];
        end
        w_d[15] = w_next;
        // The counter wraps 63 -> 0 on its own when ROUND is left.
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = ST_FINAL;
        end
      end

      ST_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          h_out_d[255 - 32*i -: 32] = hr_q[i] + v_q[i];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      h_out_q <= '0;
      done_q  <= 1'b0;
      // NOTE: the register arrays are cleared explicitly. Reset must wipe
      // the in-flight block, so they cannot be left as uninitialised RAM.
      for (int i = 0; i < 8; i++) begin
        v_q[i]  <= '0;
        hr_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      // NOTE: use non-blocking assignments only. Every flop then samples its
      // _d from the same pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      hr_q    <= hr_d;
      w_q     <= w_d;
      h_out_q <= h_out_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign bus.k_round = (state_q == ST_ROUND) ? cnt_q : 6'd0;
  assign bus.done    = done_q;
  assign bus.h_out   = h_out_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
module tb_sha256_round_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_round_engine_if bus ();

  sha256_round_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Standard SHA-256 round constants. The corrupt_k37 flag flips one bit of K[37].
  logic [31:0] k_table [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic corrupt_k37;

  always_comb begin
    bus.k_const = k_table[bus.k_round];
    if (corrupt_k37 && bus.k_round == 6'd37) bus.k_const = k_table[37] ^ 32'h0000_0001;
  end

  localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_2     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    logic [511:0] blk;
    logic [255:0] hin;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [2];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_differs(input string name, input logic [255:0] act, input logic [255:0] not_exp);
    checks++;
    if (act === not_exp) begin
      failures++;
      $display("FAIL %s: got %h which must differ from %h", name, act, not_exp);
    end
  endtask

  // Runs one block, or a two-block chain when chain=1 with start held high.
  // n counts negedges: n is the cycle after edge E_n, and E0 is the start edge.
  // Pulses p1/p2 raise start with blk2 so that it is sampled at edge E_p.
  task automatic run_block(input logic [511:0] blk, input logic [511:0] blk2, input logic [255:0] hin,
                           input bit chain, input int p1, input int p2,
                           output int first_done, output int second_done,
                           output int done_cnt, output int kbad);
    int last_busy;
    int m;
    logic [5:0] k_exp;
    logic busy_exp, done_exp;
    last_busy   = chain ? 131 : 65;
    first_done  = -1;
    second_done = -1;
    done_cnt    = 0;
    kbad        = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.block_in = blk;
    bus.h_in     = hin;
    @(posedge clk);
    for (int n = 0; n < last_busy + 3; n++) begin
      @(negedge clk);
      if (!chain && n == 0) bus.start = 1'b0;
      if (n == p1 - 1 || n == p2 - 1) begin
        bus.start    = 1'b1;
        bus.block_in = blk2;
      end
      if (n == p1 || n == p2) bus.start = 1'b0;
      m = n % 66;
      if (n > last_busy) begin
        k_exp = 6'd0; busy_exp = 1'b0; done_exp = 1'b0;
      end else if (m < 64) begin
        k_exp = 6'(m); busy_exp = 1'b1; done_exp = 1'b0;
      end else if (m == 64) begin
        k_exp = 6'd0; busy_exp = 1'b1; done_exp = 1'b0;
      end else begin
        k_exp = 6'd0; busy_exp = 1'b0; done_exp = 1'b1;
      end
      if (bus.k_round !== k_exp || bus.busy !== busy_exp || bus.done !== done_exp) kbad++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
        else if (second_done < 0) second_done = n;
      end
      if (chain && bus.done === 1'b1 && n == first_done) begin
        bus.h_in     = bus.h_out;
        bus.block_in = blk2;
      end
      if (chain && n == second_done) bus.start = 1'b0;
    end
  endtask

  initial begin
    int fd, sd, dc, kb;
    vecs[0] = '{blk: BLK_ABC,   hin: IV, exp: DIG_ABC};
    vecs[1] = '{blk: BLK_EMPTY, hin: IV, exp: DIG_EMPTY};

    rst          = 1'b1;
    corrupt_k37  = 1'b0;
    bus.start    = 1'b0;
    bus.block_in = '0;
    bus.h_in     = '0;
    #1;
    check("reset_busy",    256'(bus.busy),    256'd0);
    check("reset_done",    256'(bus.done),    256'd0);
    check("reset_k_round", 256'(bus.k_round), 256'd0);
    check("reset_h_out",   bus.h_out,         256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven single blocks: digest, 65-cycle latency, one done pulse,
    // and the k_round/busy/done sequence on every cycle.
    for (int i = 0; i < 2; i++) begin
      run_block(vecs[i].blk, '0, vecs[i].hin, 1'b0, -1, -1, fd, sd, dc, kb);
      check($sformatf("vec%0d_digest", i),   bus.h_out, vecs[i].exp);
      check($sformatf("vec%0d_latency", i),  256'(fd),  256'd65);
      check($sformatf("vec%0d_done_cnt", i), 256'(dc),  256'd1);
      check($sformatf("vec%0d_protocol", i), 256'(kb),  256'd0);
    end

    // A corrupted K[37] must change the digest.
    corrupt_k37 = 1'b1;
    run_block(BLK_ABC, '0, IV, 1'b0, -1, -1, fd, sd, dc, kb);
    check_differs("corrupt_k37_digest", bus.h_out, DIG_ABC);
    corrupt_k37 = 1'b0;

    // Start pulses at E10 and E40 with a different block must be ignored.
    run_block(BLK_ABC, BLK_EMPTY, IV, 1'b0, 10, 40, fd, sd, dc, kb);
    check("busy_start_digest",   bus.h_out, DIG_ABC);
    check("busy_start_done_cnt", 256'(dc),  256'd1);
    check("busy_start_protocol", 256'(kb),  256'd0);

    // Two-block chain with start held high and h_out fed back into h_in.
    run_block(BLK_2A, BLK_2B, IV, 1'b1, -1, -1, fd, sd, dc, kb);
    check("chain_digest",   bus.h_out,     DIG_2);
    check("chain_spacing",  256'(sd - fd), 256'd66);
    check("chain_done_cnt", 256'(dc),      256'd2);
    check("chain_protocol", 256'(kb),      256'd0);

    // Asynchronous reset during round 30, applied away from any clock edge.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.block_in = BLK_ABC;
    bus.h_in     = IV;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    check("pre_reset_k_round", 256'(bus.k_round), 256'd30);
    rst = 1'b1;
    #1;
    check("midrst_busy",    256'(bus.busy),    256'd0);
    check("midrst_done",    256'(bus.done),    256'd0);
    check("midrst_k_round", 256'(bus.k_round), 256'd0);
    check("midrst_h_out",   bus.h_out,         256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dc++;
    end
    check("midrst_no_done", 256'(dc), 256'd0);

    run_block(BLK_ABC, '0, IV, 1'b0, -1, -1, fd, sd, dc, kb);
    check("post_reset_digest",  bus.h_out, DIG_ABC);
    check("post_reset_latency", 256'(fd),  256'd65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
